// File: rtl/instr_mem_responder.sv
// Instruction fetch responder: grants fetch requests, reads a word-organised program
// memory at grant time and returns data in order after a fixed pipeline latency.
module instr_mem_responder #(
  parameter int unsigned MEM_WORDS        = 1024,
  parameter logic [31:0] BASE_ADDR        = 32'h0000_0000,
  parameter int unsigned LATENCY          = 1,
  parameter int unsigned MAX_OUTSTANDING  = 2,
  parameter int unsigned GNT_STALL_PERIOD = 0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         instr_req,
  input  logic [31:0]                  instr_addr,
  output logic                         instr_gnt,
  output logic [31:0]                  instr_rdata,
  output logic                         instr_err,
  output logic                         instr_valid,
  input  logic                         load_en,
  input  logic [$clog2(MEM_WORDS)-1:0] load_addr,
  input  logic [31:0]                  load_data,
  output logic                         busy
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned OW = 3;
  localparam logic [32:0] MEM_BYTES = {1'b0, 32'(MEM_WORDS)} << 2;

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("instr_mem_responder: LATENCY must be in 1..4");
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > LATENCY + 1) begin : g_bad_outstanding
    $error("instr_mem_responder: MAX_OUTSTANDING must be in 1..LATENCY+1");
  end
  if (GNT_STALL_PERIOD == 1) begin : g_bad_stall
    $error("instr_mem_responder: GNT_STALL_PERIOD must be 0 or >= 2");
  end
  if (MEM_WORDS < 4 || (MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_depth
    $error("instr_mem_responder: MEM_WORDS must be a power of two >= 4");
  end
  if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
    $error("instr_mem_responder: BASE_ADDR must be 4-byte aligned");
  end

  logic [31:0]               mem_r [MEM_WORDS];
  logic [31:0]               offset_s;
  logic                      in_range_s;
  logic [AW-1:0]             index_s;
  logic [31:0]               rd_data_s;
  logic                      stall_s;
  logic                      free_s;
  logic                      accept_s;
  logic [OW-1:0]             out_cnt_r;
  logic [OW-1:0]             out_cnt_nxt_s;
  logic                      busy_r;
  logic [LATENCY-1:0]        vld_r;
  logic [LATENCY-1:0]        err_r;
  logic [LATENCY-1:0][31:0]  data_r;

  // Address decode and memory read for the request being presented
  always_comb begin
    offset_s   = instr_addr - BASE_ADDR;
    in_range_s = 1'b0;
    if ((instr_addr >= BASE_ADDR) && ({1'b0, offset_s} < MEM_BYTES)) begin
      in_range_s = 1'b1;
    end else begin
      in_range_s = 1'b0;
    end
    index_s   = offset_s[AW+1:2];
    rd_data_s = in_range_s ? mem_r[index_s] : 32'h0000_0000;
  end

  if (GNT_STALL_PERIOD >= 2) begin : g_stall
    localparam int unsigned SW = $clog2(GNT_STALL_PERIOD);
    logic [SW-1:0] stall_cnt_r;

    // Free-running phase counter; the last phase suppresses the grant
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        stall_cnt_r <= SW'(0);
      end else if (stall_cnt_r == SW'(GNT_STALL_PERIOD - 1)) begin
        stall_cnt_r <= SW'(0);
      end else begin
        stall_cnt_r <= stall_cnt_r + SW'(1);
      end
    end

    assign stall_s = (stall_cnt_r == SW'(GNT_STALL_PERIOD - 1));
  end else begin : g_no_stall
    assign stall_s = 1'b0;
  end

  // A slot frees up in the same cycle a response leaves, so a full pipe still streams
  assign free_s    = (out_cnt_r < OW'(MAX_OUTSTANDING)) | vld_r[LATENCY-1];
  assign instr_gnt = instr_req & free_s & ~stall_s;
  assign accept_s  = instr_req & instr_gnt;

  // Outstanding count update: accept adds, response retires
  always_comb begin
    out_cnt_nxt_s = out_cnt_r;
    if (accept_s && !vld_r[LATENCY-1]) begin
      out_cnt_nxt_s = out_cnt_r + OW'(1);
    end else if (!accept_s && vld_r[LATENCY-1]) begin
      out_cnt_nxt_s = out_cnt_r - OW'(1);
    end else begin
      out_cnt_nxt_s = out_cnt_r;
    end
  end

  // Outstanding counter and registered busy flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_cnt_r <= OW'(0);
      busy_r    <= 1'b0;
    end else begin
      out_cnt_r <= out_cnt_nxt_s;
      busy_r    <= (out_cnt_nxt_s != OW'(0));
    end
  end

  // Stage 0 captures the read result at grant; data holds when nothing is captured
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_r[0]  <= 1'b0;
      err_r[0]  <= 1'b0;
      data_r[0] <= 32'h0000_0000;
    end else begin
      vld_r[0] <= accept_s;
      err_r[0] <= accept_s & ~in_range_s;
      if (accept_s) begin
        data_r[0] <= rd_data_s;
      end
    end
  end

  for (genvar g = 1; g < LATENCY; g++) begin : g_stage
    // Later stages forward only valid entries so the output data holds between responses
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        vld_r[g]  <= 1'b0;
        err_r[g]  <= 1'b0;
        data_r[g] <= 32'h0000_0000;
      end else begin
        vld_r[g] <= vld_r[g-1];
        err_r[g] <= vld_r[g-1] & err_r[g-1];
        if (vld_r[g-1]) begin
          data_r[g] <= data_r[g-1];
        end
      end
    end
  end

  // Program memory write port; a same-edge fetch sees the old word
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem_r[load_addr] <= load_data;
    end
  end

  assign instr_valid = vld_r[LATENCY-1];
  assign instr_err   = err_r[LATENCY-1];
  assign instr_rdata = data_r[LATENCY-1];
  assign busy        = busy_r;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder: three instances cover default timing,
// a long-latency offset-base configuration and a periodic grant stall.
module tb_instr_mem_responder;

  logic        clk;
  logic        reset_n;
  logic        load_en;
  logic [9:0]  load_addr;
  logic [31:0] load_data;

  logic        a_req, a_gnt, a_err, a_valid, a_busy;
  logic [31:0] a_addr, a_rdata;
  logic        b_req, b_gnt, b_err, b_valid, b_busy;
  logic [31:0] b_addr, b_rdata;
  logic        c_req, c_gnt, c_err, c_valid, c_busy;
  logic [31:0] c_addr, c_rdata;

  int          checks;
  int          errors;
  int unsigned cyc_q;
  logic [31:0] exp_mem [1024];

  instr_mem_responder u_dut_a (
    .clk(clk), .reset_n(reset_n), .instr_req(a_req), .instr_addr(a_addr),
    .instr_gnt(a_gnt), .instr_rdata(a_rdata), .instr_err(a_err), .instr_valid(a_valid),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .busy(a_busy)
  );

  instr_mem_responder #(
    .BASE_ADDR(32'h8000_0000), .LATENCY(3), .MAX_OUTSTANDING(2)
  ) u_dut_b (
    .clk(clk), .reset_n(reset_n), .instr_req(b_req), .instr_addr(b_addr),
    .instr_gnt(b_gnt), .instr_rdata(b_rdata), .instr_err(b_err), .instr_valid(b_valid),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .busy(b_busy)
  );

  instr_mem_responder #(
    .GNT_STALL_PERIOD(4)
  ) u_dut_c (
    .clk(clk), .reset_n(reset_n), .instr_req(c_req), .instr_addr(c_addr),
    .instr_gnt(c_gnt), .instr_rdata(c_rdata), .instr_err(c_err), .instr_valid(c_valid),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .busy(c_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles since reset release; equals the stall phase of instance c modulo 4
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc_q <= 0;
    else          cyc_q <= cyc_q + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input int idx, input logic [31:0] data);
    load_en   = 1'b1;
    load_addr = 10'(idx);
    load_data = data;
    exp_mem[idx] = data;
    tick();
    load_en = 1'b0;
  endtask

  // Single isolated fetch on instance b (latency 3)
  task automatic fetch_b(input string tag, input logic [31:0] addr,
                         input logic exp_err, input logic [31:0] exp_data);
    b_req  = 1'b1;
    b_addr = addr;
    #1;
    check_eq({tag, "_gnt"}, b_gnt, 1'b1);
    tick();
    b_req = 1'b0;
    check_eq({tag, "_v1"}, b_valid, 1'b0);
    tick();
    check_eq({tag, "_v2"}, b_valid, 1'b0);
    tick();
    check_eq({tag, "_valid"}, b_valid, 1'b1);
    check_eq({tag, "_err"}, b_err, exp_err);
    check_eq({tag, "_data"}, b_rdata, exp_data);
    tick();
    check_eq({tag, "_errclr"}, b_err, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [11:0] exp_g;
    logic [11:0] exp_v;
    int          grants;
    int          resp;
    logic        prev_g;

    checks = 0; errors = 0;
    reset_n = 1'b0; load_en = 1'b0; load_addr = 10'd0; load_data = 32'h0;
    a_req = 1'b0; a_addr = 32'h0; b_req = 1'b0; b_addr = 32'h0;
    c_req = 1'b0; c_addr = 32'h0;

    tick();
    check_eq("rst_valid", a_valid, 1'b0);
    check_eq("rst_err", a_err, 1'b0);
    check_eq("rst_rdata", a_rdata, 32'h0);
    check_eq("rst_busy", a_busy, 1'b0);
    tick();
    reset_n = 1'b1;

    load_word(0, 32'h0000_0013);
    load_word(1, 32'h0040_0093);
    load_word(2, 32'h0010_0113);
    load_word(3, 32'h0000_006F);
    load_word(4, 32'h0000_0513);
    load_word(5, 32'h00A0_0593);
    load_word(1023, 32'h1234_5678);

    // Back-to-back fetches with latency 1
    a_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a_addr = 32'(4 * k);
      #1;
      check_eq("a_gnt", a_gnt, 1'b1);
      tick();
      check_eq("a_valid", a_valid, 1'b1);
      check_eq("a_err", a_err, 1'b0);
      check_eq("a_data", a_rdata, exp_mem[k]);
    end
    a_req = 1'b0;
    tick();
    check_eq("a_idle_valid", a_valid, 1'b0);
    check_eq("a_hold_data", a_rdata, 32'h0010_0113);
    check_eq("a_idle_busy", a_busy, 1'b0);

    // Latency 3 with two outstanding: grant pattern 1,1,0 and in-order responses
    exp_g  = 12'b0000_1101_1011;
    exp_v  = 12'b0110_1101_1000;
    grants = 0;
    resp   = 0;
    for (int t = 0; t < 12; t++) begin
      b_req  = (t < 9);
      b_addr = 32'h8000_0000 + 32'(4 * grants);
      #1;
      check_eq("b_gnt_pat", b_gnt, exp_g[t]);
      check_eq("b_valid_pat", b_valid, exp_v[t]);
      check_eq("b_busy_pat", b_busy, (t >= 1 && t <= 10));
      if (exp_v[t]) begin
        check_eq("b_order_data", b_rdata, exp_mem[resp]);
        check_eq("b_order_err", b_err, 1'b0);
        resp++;
      end
      if (exp_g[t]) grants++;
      tick();
    end
    check_eq("b_resp_count", 32'(resp), 32'd6);

    // Range boundaries around BASE_ADDR = 0x8000_0000
    fetch_b("b_below", 32'h7FFF_FFFC, 1'b1, 32'h0);
    fetch_b("b_above", 32'h8000_1000, 1'b1, 32'h0);
    fetch_b("b_last",  32'h8000_0FFE, 1'b0, 32'h1234_5678);

    // Periodic stall on instance c, request held on word 4
    c_req  = 1'b1;
    c_addr = 32'h0000_0010;
    prev_g = 1'b0;
    for (int t = 0; t < 8; t++) begin
      #1;
      check_eq("c_gnt_stall", c_gnt, ((cyc_q % 4) != 3));
      check_eq("c_valid", c_valid, prev_g);
      if (prev_g) check_eq("c_data", c_rdata, exp_mem[4]);
      prev_g = ((cyc_q % 4) != 3);
      tick();
    end
    c_req = 1'b0;

    // Load and fetch of the same word on one edge: old data returned
    a_req = 1'b1;
    a_addr = 32'h0000_0008;
    load_en = 1'b1;
    load_addr = 10'd2;
    load_data = 32'hDEAD_BEEF;
    #1;
    check_eq("rbw_gnt", a_gnt, 1'b1);
    tick();
    load_en = 1'b0;
    exp_mem[2] = 32'hDEAD_BEEF;
    check_eq("rbw_old", a_rdata, 32'h0010_0113);
    check_eq("rbw_valid", a_valid, 1'b1);
    tick();
    check_eq("rbw_new", a_rdata, 32'hDEAD_BEEF);
    a_req = 1'b0;
    tick();

    // Reset with two requests in flight on instance b
    b_req = 1'b1;
    b_addr = 32'h8000_0000;
    tick();
    b_addr = 32'h8000_0004;
    tick();
    b_req = 1'b0;
    check_eq("mid_busy_pre", b_busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check_eq("mid_valid", b_valid, 1'b0);
    check_eq("mid_busy", b_busy, 1'b0);
    tick();
    reset_n = 1'b1;
    for (int t = 0; t < 5; t++) begin
      tick();
      check_eq("post_rst_valid", b_valid, 1'b0);
      check_eq("post_rst_busy", b_busy, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
